// File: rtl/hack_memory_map.sv
// Hack computer memory map: data RAM, screen framebuffer, keyboard register
// and a framebuffer scan engine streaming words to a display sink.
module hack_memory_map #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 15,
    parameter int RAM_DEPTH    = 16384,
    parameter int SCREEN_BASE  = 16384,
    parameter int SCREEN_DEPTH = 8192,
    parameter int KBD_ADDR     = 24576
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_W-1:0]               address,
    input  logic                            load,
    input  logic [DATA_W-1:0]               in,
    output logic [DATA_W-1:0]               out,
    input  logic [DATA_W-1:0]               kbd_code,
    input  logic                            scan_start,
    input  logic                            scan_ready,
    output logic                            scan_valid,
    output logic [DATA_W-1:0]               scan_data,
    output logic [$clog2(SCREEN_DEPTH)-1:0] scan_index,
    output logic                            scan_busy,
    output logic                            scan_done
);

    localparam int RW = $clog2(RAM_DEPTH);
    localparam int IW = $clog2(SCREEN_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(SCREEN_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_e;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DATA_W-1:0] scr_q [SCREEN_DEPTH];

    logic [31:0]       addr_w;
    logic              is_ram;
    logic              is_scr;
    logic              is_kbd;
    logic [RW-1:0]     ram_off;
    logic [IW-1:0]     scr_off;

    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] kbd_q;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [IW-1:0]     sidx_q, sidx_d;
    logic              done_q, done_d;

    assign addr_w  = 32'(address);
    assign is_ram  = addr_w < 32'(RAM_DEPTH);
    assign is_scr  = (addr_w >= 32'(SCREEN_BASE)) &&
                     (addr_w < 32'(SCREEN_BASE + SCREEN_DEPTH));
    assign is_kbd  = addr_w == 32'(KBD_ADDR);
    assign ram_off = RW'(addr_w);
    assign scr_off = IW'(addr_w - 32'(SCREEN_BASE));

    // Array writes; contents survive reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (load && is_ram) ram_q[ram_off] <= in;
        if (load && is_scr) scr_q[scr_off] <= in;
    end

    // CPU read mux; unmapped addresses read as zero.
    always_comb begin
        rd_d = '0;
        unique case (1'b1)
            is_ram:  rd_d = ram_q[ram_off];
            is_scr:  rd_d = scr_q[scr_off];
            is_kbd:  rd_d = kbd_q;
            default: rd_d = '0;
        endcase
    end

    // Registered CPU read data and keyboard sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            kbd_q <= '0;
        end else begin
            out_q <= rd_d;
            kbd_q <= kbd_code;
        end
    end

    // Scan engine next-state: fetch a word, hold it until accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sdata_d = sdata_q;
        sidx_d  = sidx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                sdata_d = scr_q[idx_q];
                sidx_d  = idx_q;
                state_d = HOLD;
            end
            HOLD: begin
                if (scan_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sdata_q <= '0;
            sidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sdata_q <= sdata_d;
            sidx_q  <= sidx_d;
            done_q  <= done_d;
        end
    end

    assign out        = out_q;
    assign scan_valid = state_q == HOLD;
    assign scan_busy  = state_q != IDLE;
    assign scan_data  = sdata_q;
    assign scan_index = sidx_q;
    assign scan_done  = done_q;

endmodule

// File: tb/tb_hack_memory_map.sv
// Directed bench for hack_memory_map: CPU decode, keyboard, framebuffer
// scan with stalls, same-cycle write hazards and mid-scan reset.
module tb_hack_memory_map;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] address;
    logic        load;
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] kbd_code;
    logic        scan_start;
    logic        scan_ready;
    logic        scan_valid;
    logic [15:0] scan_data;
    logic [12:0] scan_index;
    logic        scan_busy;
    logic        scan_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hack_memory_map dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .load       (load),
        .in         (din),
        .out        (dout),
        .kbd_code   (kbd_code),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .scan_index (scan_index),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(int n);
        return (n == 100) ? 16'hBEEF : 16'(n);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; address = '0; load = 1'b0; din = '0;
        kbd_code = '0; scan_start = 1'b0; scan_ready = 1'b0;
        tick();
        tick();
        total++;
        if (dout !== 16'h0) $display("FAIL reset_out: got %h want 0000", dout);
        else passed++;
        total++;
        if ({scan_valid, scan_busy, scan_done} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000",
                     {scan_valid, scan_busy, scan_done});
        else passed++;
        total++;
        if ({scan_data, scan_index} !== 29'h0)
            $display("FAIL reset_scan: got %h/%h want 0/0", scan_data, scan_index);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        address = 15'd5; din = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (dout !== 16'h1234) $display("FAIL ram_rd5: got %h want 1234", dout);
        else passed++;
        address = 15'd16389; din = 16'h0777; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (dout !== 16'h0777) $display("FAIL scr_rd5: got %h want 0777", dout);
        else passed++;
        address = 15'd5;
        tick();
        total++;
        if (dout !== 16'h1234) $display("FAIL ram_rd5_again: got %h want 1234", dout);
        else passed++;
        din = 16'hAAAA; load = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (dout !== 16'h1234) $display("FAIL ram_rdw_old: got %h want 1234", dout);
        else passed++;
        tick();
        total++;
        if (dout !== 16'hAAAA) $display("FAIL ram_rdw_new: got %h want AAAA", dout);
        else passed++;
    endtask

    task automatic test_kbd();
        kbd_code = 16'h0041;
        address = 15'd24576; din = 16'hFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (dout !== 16'h0041) $display("FAIL kbd_rd: got %h want 0041", dout);
        else passed++;
        kbd_code = 16'h0042;
        tick();
        total++;
        if (dout !== 16'h0041) $display("FAIL kbd_lag: got %h want 0041", dout);
        else passed++;
        tick();
        total++;
        if (dout !== 16'h0042) $display("FAIL kbd_new: got %h want 0042", dout);
        else passed++;
        address = 15'd30000;
        tick();
        total++;
        if (dout !== 16'h0000) $display("FAIL unmapped_rd: got %h want 0000", dout);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8192; i++) begin
            address = 15'(16384 + i); din = 16'(i); load = 1'b1;
            tick();
        end
        load = 1'b0;
        address = 15'd24575;
        tick();
        total++;
        if (dout !== 16'd8191) $display("FAIL fill_last: got %h want 1fff", dout);
        else passed++;
    endtask

    task automatic test_scan_full();
        int nexp = 0;
        int bad = 0;
        int gapbad = 0;
        int dones = 0;
        int done_at = -1;
        logic f200 = 1'b0;
        logic [15:0] out201 = '0;
        logic [15:0] out202 = '0;
        scan_ready = 1'b1; scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        total++;
        if ({scan_busy, scan_valid} !== 2'b10)
            $display("FAIL scan_first_fetch: got %b want 10", {scan_busy, scan_valid});
        else passed++;
        for (int c = 1; c <= 16390; c++) begin
            tick();
            scan_start = (c == 50);
            if (scan_valid) begin
                if (scan_index !== 13'(nexp) || scan_data !== 16'(nexp)) begin
                    if (bad < 4)
                        $display("FAIL scan_word: got %h@%0d want %h@%0d",
                                 scan_data, scan_index, 16'(nexp), nexp);
                    bad++;
                end
                if (c != 2 * nexp + 1) gapbad++;
                nexp++;
            end
            if (scan_done) begin
                dones++;
                done_at = c;
            end
            if (c == 200) begin
                f200 = scan_busy && !scan_valid;
                address = 15'd16484; din = 16'hBEEF; load = 1'b1;
            end
            if (c == 201) begin
                load = 1'b0;
                out201 = dout;
            end
            if (c == 202) out202 = dout;
        end
        total++;
        if (nexp != 8192) $display("FAIL scan_count: got %0d want 8192", nexp);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL scan_order: got %0d bad want 0", bad);
        else passed++;
        total++;
        if (gapbad != 0) $display("FAIL scan_timing: got %0d bad want 0", gapbad);
        else passed++;
        total++;
        if (dones != 1) $display("FAIL scan_done_cnt: got %0d want 1", dones);
        else passed++;
        total++;
        if (done_at != 16384) $display("FAIL scan_done_at: got %0d want 16384", done_at);
        else passed++;
        total++;
        if (f200 !== 1'b1) $display("FAIL fetch100_state: got %b want 1", f200);
        else passed++;
        total++;
        if (out201 !== 16'd100) $display("FAIL cpu_rdw100: got %h want 0064", out201);
        else passed++;
        total++;
        if (out202 !== 16'hBEEF) $display("FAIL cpu_rd100: got %h want BEEF", out202);
        else passed++;
        total++;
        if ({scan_busy, scan_valid} !== 2'b00)
            $display("FAIL scan_idle: got %b want 00", {scan_busy, scan_valid});
        else passed++;
    endtask

    task automatic test_stall_reset();
        int nexp = 0;
        int orderbad = 0;
        int stallbad = 0;
        int dones = 0;
        logic hit = 1'b0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [15:0] pd = '0;
        logic [12:0] pi = '0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0; scan_ready = 1'b0;
        for (int c = 0; c < 30000 && !hit; c++) begin
            tick();
            if (scan_done) dones++;
            if (scan_valid) begin
                if (pv && !pr) begin
                    if (scan_data !== pd || scan_index !== pi) stallbad++;
                end else begin
                    if (scan_index !== 13'(nexp) || scan_data !== exp_word(nexp))
                        orderbad++;
                    nexp++;
                end
                pd = scan_data;
                pi = scan_index;
                if (scan_index == 13'd3000) hit = 1'b1;
            end
            pv = scan_valid;
            scan_ready = 1'($urandom_range(0, 1));
            pr = scan_ready;
        end
        total++;
        if (hit !== 1'b1) $display("FAIL stall_reach3000: got %b want 1", hit);
        else passed++;
        total++;
        if (orderbad != 0) $display("FAIL stall_order: got %0d bad want 0", orderbad);
        else passed++;
        total++;
        if (stallbad != 0) $display("FAIL stall_stable: got %0d bad want 0", stallbad);
        else passed++;
        total++;
        if (nexp != 3001) $display("FAIL stall_count: got %0d want 3001", nexp);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dout, scan_data, scan_index} !== 45'h0)
            $display("FAIL async_rst_data: got %h/%h/%h want 0/0/0",
                     dout, scan_data, scan_index);
        else passed++;
        total++;
        if ({scan_valid, scan_busy, scan_done} !== 3'b000)
            $display("FAIL async_rst_flags: got %b want 000",
                     {scan_valid, scan_busy, scan_done});
        else passed++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (scan_done) dones++;
        end
        rst_n = 1'b1; scan_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (scan_done) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL rst_no_done: got %0d want 0", dones);
        else passed++;
        address = 15'd5;
        tick();
        total++;
        if (dout !== 16'hAAAA) $display("FAIL rst_ram_kept: got %h want AAAA", dout);
        else passed++;
        address = 15'd16484;
        tick();
        total++;
        if (dout !== 16'hBEEF) $display("FAIL rst_scr_kept: got %h want BEEF", dout);
        else passed++;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        total++;
        if (!scan_valid || scan_index !== 13'd0 || scan_data !== 16'd0)
            $display("FAIL restart_w0: got %b %h@%0d want 1 0000@0",
                     scan_valid, scan_data, scan_index);
        else passed++;
        tick();
        tick();
        total++;
        if (!scan_valid || scan_index !== 13'd1 || scan_data !== 16'd1)
            $display("FAIL restart_w1: got %b %h@%0d want 1 0001@1",
                     scan_valid, scan_data, scan_index);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_kbd();
        test_fill();
        test_scan_full();
        test_stall_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
